ov7670_dvp_source: RTL and testbench

- Synthesizable OV7670 DVP transmitter (camera emulator).
- Generates PCLK, VSYNC, HREF and an 8-bit RGB565 byte stream with OV7670-style frame timing.
- Drives the camera receive path and the framebuffer/VGA chain in simulation and board bring-up, with no sensor attached.
- Sits in the 25 MHz domain. Its outputs connect where cam_PCLK/cam_VSYNC/cam_HREF/cam_data normally enter.

---
 rtl/ov7670_pkg.sv | 31 +++
 rtl/ov7670_pattern_gen.sv | 39 +++
 rtl/ov7670_dvp_source.sv | 150 +++++++++++++++
 tb/tb_ov7670_dvp_source.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared types and helpers for the OV7670 DVP camera emulator.
package ov7670_pkg;

   typedef enum logic [2:0] {
      IDLE,
      VSYNC,
      VBACK,
      ACTIVE,
      VFRONT
   } state_t;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   localparam int unsigned BAR_COUNT = 8;

   // white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [15:0] BAR_TABLE [BAR_COUNT] = '{
      16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
      16'hF81F, 16'hF800, 16'h001F, 16'h0000
   };

   // First byte on the bus carries red and the top of green, second byte the rest.
   function automatic logic [7:0] split_byte(input rgb565_t pix, input logic phase);
      return phase ? {pix.g[2:0], pix.b} : {pix.r, pix.g[5:3]};
   endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Combinational RGB565 test-pattern generator indexed by active pixel position.
module ov7670_pattern_gen
   import ov7670_pkg::*;
#(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned XW       = 10,
   parameter int unsigned YW       = 10
) (
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   input  logic [1:0]    pattern,
   input  logic [7:0]    frame_count,
   output rgb565_t       pixel_c
);
   localparam int unsigned BAR_W = H_ACTIVE / BAR_COUNT;

   logic [2:0] bar_idx_c;
   logic       unused_c;

   assign bar_idx_c = 3'(x / XW'(BAR_W));
   assign unused_c  = ^{y[YW-1:6], y[4:0], frame_count[7:5]};

   always_comb begin
      pixel_c = '0;
      case (pattern)
         2'd0: pixel_c = rgb565_t'(BAR_TABLE[bar_idx_c]);
         2'd1: begin
            pixel_c.r = x[9:5];
            pixel_c.g = x[9:4];
         end
         2'd2: pixel_c = (x[5] ^ y[5]) ? rgb565_t'(16'hFFFF) : rgb565_t'(16'h0000);
         default: begin
            pixel_c.r = frame_count[4:0];
            pixel_c.b = ~frame_count[4:0];
         end
      endcase
   end

endmodule

// File: rtl/ov7670_dvp_source.sv
// OV7670-style DVP camera emulator: PCLK divider, frame timing FSM and RGB565 byte stream.
module ov7670_dvp_source
   import ov7670_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_BLANK     = 144,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned VSYNC_LINES = 3,
   parameter int unsigned V_BACK      = 17,
   parameter int unsigned V_FRONT     = 10,
   parameter int unsigned CLK_DIV     = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   output logic       cam_PCLK,
   output logic       cam_VSYNC,
   output logic       cam_HREF,
   output logic [7:0] cam_data,
   output logic       frame_start,
   output logic [7:0] frame_count
);
   localparam int unsigned LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
   localparam int unsigned FRAME_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
   localparam int unsigned ACT_START   = VSYNC_LINES + V_BACK;
   localparam int unsigned ACT_END     = ACT_START + V_ACTIVE;
   localparam int unsigned HALF        = CLK_DIV / 2;
   localparam int unsigned DW          = $clog2(CLK_DIV);
   localparam int unsigned HW          = $clog2(LINE_LEN);
   localparam int unsigned VW          = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
   localparam int unsigned XW          = (HW - 1 > 10) ? HW - 1 : 10;
   localparam int unsigned YW          = (VW > 10) ? VW : 10;

   state_t        state, state_n;
   logic [DW-1:0] div, div_n;
   logic [HW-1:0] hcnt, hcnt_n;
   logic [VW-1:0] vcnt, vcnt_n;
   logic [1:0]    pat, pat_n;
   logic          pclk_n, vsync_n, href_n, frame_start_n;
   logic [7:0]    data_n, frame_count_n;
   logic          tick_c, line_end_c;
   logic [XW-1:0] x_c;
   logic [YW-1:0] y_c;
   rgb565_t       pixel_c;

   // Timing advances once per PCLK period, in the clk cycle where PCLK falls.
   assign tick_c     = (div == DW'(HALF - 1));
   assign line_end_c = (hcnt == HW'(LINE_LEN - 1));
   assign x_c        = XW'(hcnt_n >> 1);
   assign y_c        = YW'(vcnt_n - VW'(ACT_START));

   ov7670_pattern_gen #(
      .H_ACTIVE (H_ACTIVE),
      .XW       (XW),
      .YW       (YW)
   ) u_pattern (
      .x           (x_c),
      .y           (y_c),
      .pattern     (pat),
      .frame_count (frame_count),
      .pixel_c     (pixel_c)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         div         <= '0;
         hcnt        <= '0;
         vcnt        <= '0;
         pat         <= '0;
         cam_PCLK    <= 1'b0;
         cam_VSYNC   <= 1'b0;
         cam_HREF    <= 1'b0;
         cam_data    <= '0;
         frame_start <= 1'b0;
         frame_count <= '0;
      end else begin
         state       <= state_n;
         div         <= div_n;
         hcnt        <= hcnt_n;
         vcnt        <= vcnt_n;
         pat         <= pat_n;
         cam_PCLK    <= pclk_n;
         cam_VSYNC   <= vsync_n;
         cam_HREF    <= href_n;
         cam_data    <= data_n;
         frame_start <= frame_start_n;
         frame_count <= frame_count_n;
      end
   end

   // Divider, line/frame counters and state sequencing.
   always_comb begin
      state_n       = state;
      hcnt_n        = hcnt;
      vcnt_n        = vcnt;
      pat_n         = pat;
      frame_count_n = frame_count;
      frame_start_n = 1'b0;
      div_n         = (div == DW'(CLK_DIV - 1)) ? '0 : div + 1'b1;
      pclk_n        = (div_n < DW'(HALF));
      if (tick_c) begin
         hcnt_n = line_end_c ? '0 : hcnt + 1'b1;
         if (line_end_c) begin
            vcnt_n = vcnt + 1'b1;
            case (state)
               IDLE: begin
                  vcnt_n = '0;
                  if (enable) begin
                     state_n       = VSYNC;
                     frame_start_n = 1'b1;
                     pat_n         = pattern_sel;
                  end
               end
               VSYNC:  if (vcnt == VW'(VSYNC_LINES - 1)) state_n = VBACK;
               VBACK:  if (vcnt == VW'(ACT_START - 1))   state_n = ACTIVE;
               ACTIVE: if (vcnt == VW'(ACT_END - 1))     state_n = VFRONT;
               VFRONT: begin
                  if (vcnt == VW'(FRAME_LINES - 1)) begin
                     vcnt_n        = '0;
                     frame_count_n = frame_count + 8'd1;
                     if (enable) begin
                        state_n       = VSYNC;
                        frame_start_n = 1'b1;
                        pat_n         = pattern_sel;
                     end else begin
                        state_n = IDLE;
                     end
                  end
               end
               default: state_n = IDLE;
            endcase
         end
      end
   end

   // Bus outputs follow the position the counters are about to take.
   always_comb begin
      vsync_n = cam_VSYNC;
      href_n  = cam_HREF;
      data_n  = cam_data;
      if (tick_c) begin
         vsync_n = (state_n == VSYNC);
         href_n  = (state_n == ACTIVE) && (hcnt_n < HW'(2 * H_ACTIVE));
         data_n  = href_n ? split_byte(pixel_c, hcnt_n[0]) : 8'h00;
      end
   end

endmodule

// File: tb/tb_ov7670_dvp_source.sv
// Randomized-schedule bench for the DVP emulator against a line-level reference model.
`timescale 1ns/1ps
module tb_ov7670_dvp_source;
   localparam int HA   = 64;
   localparam int HB   = 8;
   localparam int VA   = 34;
   localparam int VS   = 2;
   localparam int VB   = 3;
   localparam int VF   = 2;
   localparam int L    = 2 * HA + HB;
   localparam int T    = VS + VB + VA + VF;
   localparam int ACT0 = VS + VB;

   logic       clk = 1'b0;
   logic       resetn, enable;
   logic [1:0] pattern_sel;
   logic       cam_PCLK, cam_VSYNC, cam_HREF, frame_start;
   logic [7:0] cam_data, frame_count;

   logic       resetn2;
   logic       pclk2, vsync2, href2, frame_start2;
   logic [7:0] data2, frame_count2;

   int n_checks = 0;
   int n_pass   = 0;
   int k, m_vline, m_fc, m_pat, m_starts, fs_seen, starts2 = 0;
   bit m_run;

   always #5 clk = ~clk;

   ov7670_dvp_source #(
      .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VSYNC_LINES(VS),
      .V_BACK(VB), .V_FRONT(VF), .CLK_DIV(2)
   ) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .pattern_sel(pattern_sel),
      .cam_PCLK(cam_PCLK), .cam_VSYNC(cam_VSYNC), .cam_HREF(cam_HREF),
      .cam_data(cam_data), .frame_start(frame_start), .frame_count(frame_count)
   );

   // Tiny frame geometry so the 8-bit frame counter can wrap within the run.
   ov7670_dvp_source #(
      .H_ACTIVE(8), .H_BLANK(2), .V_ACTIVE(1), .VSYNC_LINES(1),
      .V_BACK(1), .V_FRONT(1), .CLK_DIV(2)
   ) dut_wrap (
      .clk(clk), .resetn(resetn2), .enable(1'b1), .pattern_sel(2'd0),
      .cam_PCLK(pclk2), .cam_VSYNC(vsync2), .cam_HREF(href2),
      .cam_data(data2), .frame_start(frame_start2), .frame_count(frame_count2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
   endtask

   function automatic logic [7:0] ref_byte(input int pat, input int x, input int y,
                                           input int fc, input int odd);
      int r, g, b, bar;
      bit [15:0] w;
      r = 0; g = 0; b = 0;
      case (pat)
         0: begin
            bar = x / (HA / 8);
            r = (bar inside {0, 1, 4, 5}) ? 31 : 0;
            g = (bar inside {0, 1, 2, 3}) ? 63 : 0;
            b = (bar inside {0, 2, 4, 6}) ? 31 : 0;
         end
         1: begin
            r = (x >> 5) & 31;
            g = (x >> 4) & 63;
         end
         2: if (((x >> 5) ^ (y >> 5)) & 1) begin
            r = 31; g = 63; b = 31;
         end
         default: begin
            r = fc % 32;
            b = 31 - (fc % 32);
         end
      endcase
      w = 16'(r * 2048 + g * 32 + b);
      return (odd != 0) ? w[7:0] : w[15:8];
   endfunction

   // Reference: one step per PCLK rising edge; k counts PCLK periods since reset release.
   initial begin
      int h;
      bit ex_vs, ex_href, pclk_prev, prev_href, fs_prev;
      logic [7:0] ex_data, prev_data;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            k = 0; m_run = 0; m_vline = 0; m_fc = 0; m_pat = 0;
            m_starts = 0; fs_seen = 0;
            pclk_prev = 0; prev_data = 0; prev_href = 0; fs_prev = 0;
         end else begin
            if (frame_start) begin
               fs_seen++;
               check("fs_width", 32'(fs_prev), 32'(0));
               check("fs_vsync", 32'(cam_VSYNC), 32'(1));
            end
            if (cam_PCLK && !pclk_prev) begin
               check("hold_data", 32'(cam_data), 32'(prev_data));
               check("hold_href", 32'(cam_HREF), 32'(prev_href));
               k++;
               h = k % L;
               if (h == 0) begin
                  if (m_run) begin
                     if (m_vline == T - 1) begin
                        m_fc = (m_fc + 1) % 256;
                        if (enable) begin
                           m_vline = 0; m_pat = int'(pattern_sel); m_starts++;
                        end else begin
                           m_run = 0;
                        end
                     end else begin
                        m_vline++;
                     end
                  end else if (enable) begin
                     m_run = 1; m_vline = 0; m_pat = int'(pattern_sel); m_starts++;
                  end
               end
               ex_vs   = m_run && (m_vline < VS);
               ex_href = m_run && (m_vline >= ACT0) && (m_vline < ACT0 + VA) && (h < 2 * HA);
               ex_data = ex_href ? ref_byte(m_pat, h / 2, m_vline - ACT0, m_fc, h % 2) : 8'h00;
               check("vsync", 32'(cam_VSYNC), 32'(ex_vs));
               check("href", 32'(cam_HREF), 32'(ex_href));
               check("data", 32'(cam_data), 32'(ex_data));
               check("fcount", 32'(frame_count), 32'(m_fc));
            end
            pclk_prev = cam_PCLK;
            prev_data = cam_data;
            prev_href = cam_HREF;
            fs_prev   = frame_start;
         end
      end
   end

   // Wrap instance: at its n-th frame start the counter must read (n-1) mod 256.
   initial begin
      forever begin
         @(negedge clk);
         if (resetn2 && frame_start2) begin
            starts2++;
            check("fc_wrap", 32'(frame_count2), 32'((starts2 - 1) % 256));
         end
      end
   end

   task automatic wait_k(input int target);
      int budget;
      budget = 2 * (target - k) + 20;
      while (k < target && budget > 0) begin
         @(posedge clk);
         #2;
         budget--;
      end
      check("wait_k", 32'(k >= target), 32'(1));
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_data"}, 32'(cam_data), 32'(0));
      check({tag, "_href"}, 32'(cam_HREF), 32'(0));
      check({tag, "_vsync"}, 32'(cam_VSYNC), 32'(0));
      check({tag, "_fc"}, 32'(frame_count), 32'(0));
      check({tag, "_fs"}, 32'(frame_start), 32'(0));
      check({tag, "_pclk"}, 32'(cam_PCLK), 32'(0));
   endtask

   initial begin
      int mid;
      resetn = 1'b0; resetn2 = 1'b0; enable = 1'b1; pattern_sel = 2'd0;
      repeat (3) @(posedge clk);
      #2;
      check_zero_outputs("rst");
      resetn = 1'b1; resetn2 = 1'b1;

      // Mid-line offsets are randomized but kept clear of the line boundary.
      mid = int'($urandom_range(20, 100));
      wait_k(L * (1 + ACT0 + 10) + mid);
      pattern_sel = 2'd2;
      mid = int'($urandom_range(20, 100));
      wait_k(L * (1 + T + ACT0 + 5) + mid);
      pattern_sel = 2'd1;
      mid = int'($urandom_range(20, 100));
      wait_k(L * (1 + 2 * T + ACT0 + 10) + mid);
      enable = 1'b0;
      mid = int'($urandom_range(20, 100));
      wait_k(L * (1 + 3 * T + 3) + mid);
      check("fs_count_a", 32'(fs_seen), 32'(m_starts));
      check("idle_fc", 32'(frame_count), 32'(3));
      pattern_sel = 2'd3;
      enable = 1'b1;

      mid = int'($urandom_range(20, 100));
      wait_k(L * (1 + 3 * T + 4 + ACT0 + 7) + mid);
      check("pre_rst_href", 32'(cam_HREF), 32'(1));
      #1 resetn = 1'b0;
      #1 check_zero_outputs("async_rst");
      repeat (3) @(posedge clk);
      #2 resetn = 1'b1;

      wait_k(L * (1 + ACT0 + 3) + 10);
      check("fs_count_b", 32'(fs_seen), 32'(m_starts));

      for (int i = 0; i < 60000 && starts2 < 260; i++) @(posedge clk);
      check("wrap_frames", 32'(starts2 >= 260), 32'(1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
